// File: rtl/fa_using_ha_pkg.sv
// fa_using_ha_pkg
// Shared definitions for the registered ripple-carry adder:
//   FA_WIDTH_MAX  - widest operand the adder is meant to be built at
//   fa_result_t   - registered result bundle (sum, carry, ovf)
//   FA_RESULT_RST - value the result registers take on reset (all zeros)
package fa_using_ha_pkg;

   localparam int FA_WIDTH_MAX = 64;

   typedef struct packed {
      logic [FA_WIDTH_MAX-1:0] sum;
      logic                    carry;
      logic                    ovf;
   } fa_result_t;

   localparam fa_result_t FA_RESULT_RST = '0;

endpackage

// File: rtl/fa_using_ha_half_adder.sv
// half_adder
// Purely combinational half adder. Two of these plus an OR form one full-adder bit.
// Ports:
//   a, b : input bits
//   s    : a ^ b
//   c    : a & b
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/fa_using_ha.sv
// fa_using_ha
// Registered ripple-carry adder, WIDTH bits (1..64). Each bit is two half
// adders and an OR; the carry ripples LSB to MSB. Results are registered
// with one cycle of latency, held while En is low, and cleared by a
// synchronous active-low reset that overrides En.
// Optional feature macro: FA_USING_HA_OVF_EN adds the Ovf port and register
// (two's-complement overflow of the sum).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   En     : load enable for the output registers
//   A, B   : unsigned addends, WIDTH bits
//   Cin    : carry into bit 0
//   Sum    : registered sum, WIDTH bits
//   Carry  : registered carry out of the MSB
//   Ovf    : registered signed overflow (FA_USING_HA_OVF_EN only)
module fa_using_ha
   import fa_using_ha_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             En,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
`ifdef FA_USING_HA_OVF_EN
   output logic             Ovf,
`endif
   output logic             Carry
);

   if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
      $error("fa_using_ha: WIDTH out of range");
   end

   // c[i] is the carry into bit i; c[WIDTH] is the carry out.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             carry_d;
   logic             carry_q;

   assign c[0] = Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic p;
      logic g;
      logic h;

      half_adder u_ha_pg (
         .a (A[i]),
         .b (B[i]),
         .s (p),
         .c (g)
      );

      half_adder u_ha_sc (
         .a (p),
         .b (c[i]),
         .s (sum_d[i]),
         .c (h)
      );

      assign c[i+1] = g | h;
   end

   always_comb begin
      carry_d = c[WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= FA_RESULT_RST.sum[WIDTH-1:0];
         carry_q <= FA_RESULT_RST.carry;
      end else if (En) begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign Sum   = sum_q;
   assign Carry = carry_q;

`ifdef FA_USING_HA_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_comb begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= FA_RESULT_RST.ovf;
      end else if (En) begin
         ovf_q <= ovf_d;
      end
   end

   assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fa_using_ha.sv
module tb_fa_using_ha;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // WIDTH=1 instance
   logic        en1, a1, b1, cin1;
   logic        sum1, carry1;
   // WIDTH=4 instance
   logic        en4, cin4;
   logic [3:0]  a4, b4, sum4;
   logic        carry4;
   // WIDTH=16 instance
   logic        en16, cin16;
   logic [15:0] a16, b16, sum16;
   logic        carry16;
`ifdef FA_USING_HA_OVF_EN
   logic        ovf1, ovf4, ovf16;
`endif

   int checks = 0;
   int errors = 0;

   fa_using_ha #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .En(en1), .A(a1), .B(b1), .Cin(cin1),
      .Sum(sum1),
`ifdef FA_USING_HA_OVF_EN
      .Ovf(ovf1),
`endif
      .Carry(carry1));

   fa_using_ha #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .En(en4), .A(a4), .B(b4), .Cin(cin4),
      .Sum(sum4),
`ifdef FA_USING_HA_OVF_EN
      .Ovf(ovf4),
`endif
      .Carry(carry4));

   fa_using_ha #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .En(en16), .A(a16), .B(b16), .Cin(cin16),
      .Sum(sum16),
`ifdef FA_USING_HA_OVF_EN
      .Ovf(ovf16),
`endif
      .Carry(carry16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin : stim
      logic [7:0]  exp_sum1;
      logic [7:0]  exp_carry1;
      logic [16:0] model;
      logic        model_ovf;
      logic        ld_en;
      logic [15:0] ra, rb;
      logic        rc;

      exp_sum1   = 8'b1001_0110;   // index i = {A,B,Cin}: 0,1,1,0,1,0,0,1
      exp_carry1 = 8'b1110_1000;   // 0,0,0,1,0,1,1,1

      rst_n = 1'b0;
      en1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      en4 = 0; a4 = 0; b4 = 0; cin4 = 0;
      en16 = 0; a16 = 0; b16 = 0; cin16 = 0;
      tick();
      tick();

      chk("rst_sum1", 32'(sum1), 0);
      chk("rst_carry1", 32'(carry1), 0);
      chk("rst_sum4", 32'(sum4), 0);
      chk("rst_carry4", 32'(carry4), 0);
      chk("rst_sum16", 32'(sum16), 0);
      chk("rst_carry16", 32'(carry16), 0);
`ifdef FA_USING_HA_OVF_EN
      chk("rst_ovf4", 32'(ovf4), 0);
`endif

      rst_n = 1'b1;

      // WIDTH=1 truth table, one vector per cycle
      en1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         {a1, b1, cin1} = 3'(i);
         tick();
         chk($sformatf("w1_sum_%0d", i), 32'(sum1), 32'(exp_sum1[i]));
         chk($sformatf("w1_carry_%0d", i), 32'(carry1), 32'(exp_carry1[i]));
`ifdef FA_USING_HA_OVF_EN
         chk($sformatf("w1_ovf_%0d", i), 32'(ovf1), 32'(exp_carry1[i] ^ cin1));
`endif
      end
      en1 = 1'b0;

      // WIDTH=4 directed
      en4 = 1'b1;
      a4 = 4'hF; b4 = 4'h1; cin4 = 0;
      tick();
      chk("w4_f1_sum", 32'(sum4), 32'h0);
      chk("w4_f1_carry", 32'(carry4), 1);
`ifdef FA_USING_HA_OVF_EN
      chk("w4_f1_ovf", 32'(ovf4), 0);
`endif
      a4 = 4'h7; b4 = 4'h1; cin4 = 0;
      tick();
      chk("w4_71_sum", 32'(sum4), 32'h8);
      chk("w4_71_carry", 32'(carry4), 0);
`ifdef FA_USING_HA_OVF_EN
      chk("w4_71_ovf", 32'(ovf4), 1);
`endif
      a4 = 4'h8; b4 = 4'h8; cin4 = 0;
      tick();
      chk("w4_88_sum", 32'(sum4), 32'h0);
      chk("w4_88_carry", 32'(carry4), 1);
`ifdef FA_USING_HA_OVF_EN
      chk("w4_88_ovf", 32'(ovf4), 1);
`endif

      // Enable hold
      a4 = 4'h3; b4 = 4'h4; cin4 = 1;
      tick();
      chk("hold_load_sum", 32'(sum4), 32'h8);
      en4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a4 = 4'(4'hA + i); b4 = 4'(4'h9 - i); cin4 = 1'(i);
         tick();
         chk($sformatf("hold_sum_%0d", i), 32'(sum4), 32'h8);
         chk($sformatf("hold_carry_%0d", i), 32'(carry4), 0);
      end

      // Reset mid-stream
      en4 = 1'b1;
      a4 = 4'h7; b4 = 4'h7; cin4 = 0;
      tick();
      chk("pre_rst_sum", 32'(sum4), 32'hE);
      rst_n = 1'b0;
      a4 = 4'h5; b4 = 4'h6; cin4 = 1;
      tick();
      chk("mid_rst_sum", 32'(sum4), 0);
      chk("mid_rst_carry", 32'(carry4), 0);
`ifdef FA_USING_HA_OVF_EN
      chk("mid_rst_ovf", 32'(ovf4), 0);
`endif
      rst_n = 1'b1;
      a4 = 4'h1; b4 = 4'h1; cin4 = 1;
      tick();
      chk("post_rst_sum", 32'(sum4), 32'h3);
      chk("post_rst_carry", 32'(carry4), 0);
      en4 = 1'b0;

      // WIDTH=16 random with random enable; registers are zero after reset
      model     = '0;
      model_ovf = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         ra    = 16'($urandom);
         rb    = 16'($urandom);
         rc    = 1'($urandom);
         ld_en = 1'($urandom);
         a16 = ra; b16 = rb; cin16 = rc; en16 = ld_en;
         tick();
         if (ld_en) begin
            model     = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            model_ovf = (ra[15] == rb[15]) && (model[15] != ra[15]);
         end
         chk("rnd_sum", 32'(sum16), 32'(model[15:0]));
         chk("rnd_carry", 32'(carry16), 32'(model[16]));
`ifdef FA_USING_HA_OVF_EN
         chk("rnd_ovf", 32'(ovf16), 32'(model_ovf));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fa_using_ha.md
# fa_using_ha

Registered ripple-carry adder of parameterizable width. Each bit is a full adder built from two half adders and an OR gate. The default WIDTH=1 is the classic single-bit full adder used as a datapath leaf cell. Outputs are registered on one clock with a synchronous active-low reset, so the cell can sit directly in pipelined arithmetic paths.

## Interface
- WIDTH, default 1: operand width in bits; legal range is 1 to 64.
- One clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk.
- En  input  1  capture enable; when high, the output registers load new results.
- A  input  WIDTH  addend A, unsigned.
- B  input  WIDTH  addend B, unsigned.
- Cin  input  1  carry into bit 0.
- Sum  output  WIDTH  registered sum bits.
- Carry  output  1  registered carry out of bit WIDTH-1.
- Ovf  output  1  registered signed overflow; present only with FA_USING_HA_OVF_EN.

## Operation
- Per bit i, three stages:
  - first half adder: p_i = A[i]^B[i], g_i = A[i]&B[i].
  - second half adder: s_i = p_i^c_i, h_i = p_i&c_i.
  - carry: c_(i+1) = g_i | h_i, with c_0 = Cin.
- The carry ripples from LSB to MSB. There is no carry lookahead.
- Arithmetic: {Carry, Sum} = A + B + Cin, computed exactly in WIDTH+1 bits. No truncation beyond the carry.
- Ovf = c_WIDTH ^ c_(WIDTH-1). This is two's-complement overflow of the signed sum. For WIDTH=1, Ovf = Carry ^ Cin.
- En low: all output registers hold their values. Inputs are ignored.
- Inputs X/Z are not handled; the bench drives known values only.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N (with En=1) appear on the outputs after edge N and hold until the next loading edge.
- Reset (rst_n=0 at a rising edge): Sum=0, Carry=0, Ovf=0. Reset takes priority over En.
- Reset mid-operation: an in-flight result is discarded. The outputs read 0 on the cycle after the reset edge. The first valid result appears one cycle after rst_n returns high with En=1.
- Outputs never change between clock edges. No combinational path runs from inputs to outputs.
- The combinational ripple path (2·WIDTH gate levels) must close timing within one clock period at the target WIDTH.
- Back-to-back operations are supported: a new operand set can be loaded every cycle.

## Configuration
- FA_USING_HA_OVF_EN defined:
  - the Ovf port and its register exist;
  - Ovf is computed as described in Operation.
- FA_USING_HA_OVF_EN undefined:
  - the Ovf port is absent;
  - no overflow logic or register is synthesized;
  - Sum and Carry behaviour is unchanged.

## Structure
- Shared package fa_using_ha_pkg holds:
  - FA_WIDTH_MAX = 64;
  - a reset-value constant of all zeros;
  - the result typedef, a struct of sum, carry and ovf.
- Sub-module half_adder: ports a, b, s (= a^b), c (= a&b), purely combinational.
  - Two instances per bit, generated in a for-generate loop.
  - The OR of the two half-adder carries is inline.
- Top level: generate loop, output registers, optional overflow logic.

## Test plan
- WIDTH=1, reset, then all 8 {A,B,Cin} combinations from 000 to 111, one per cycle. The sequence after 1-cycle latency must read:
  - Sum: 0,1,1,0,1,0,0,1;
  - Carry: 0,0,0,1,0,1,1,1.
- WIDTH=4: A=4'hF, B=4'h1, Cin=0 -> Sum=4'h0, Carry=1, Ovf=0. This exercises the full ripple chain.
- WIDTH=4: A=4'h7, B=4'h1, Cin=0 -> Sum=4'h8, Carry=0, Ovf=1. Then A=4'h8, B=4'h8, Cin=0 -> Sum=4'h0, Carry=1, Ovf=1.
- En hold: load A=3, B=4, Cin=1 (result 8), then drop En and change inputs for 3 cycles. Sum must stay 4'h8, Carry 0.
- Reset mid-stream: with Sum=4'hE displayed, assert rst_n=0 for one edge. The next cycle reads Sum=0, Carry=0, Ovf=0. Release rst_n with A=1, B=1, Cin=1 -> Sum=3 one cycle later.
- Random: 1000 cycles at WIDTH=16 with random En. Each loaded result is compared to the A+B+Cin reference model.
